div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 125 ++++++++++++
 tb/tb_div_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative 32-bit integer divider for the EX stage. It handles DIV and DIVU
// with a restoring radix-2 loop, one quotient bit per cycle. A non-zero divisor
// takes 33 cycles from the start sample to ready. A zero divisor takes 2 cycles
// and returns zero.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, ZERO, BUSY, DONE} stateT;

  stateT       stateReg, stateNext;
  logic [5:0]  countReg;
  logic [31:0] remReg, quoReg, divMagReg;
  logic        negQuoReg, negRemReg;
  logic [63:0] resultReg;

  logic        accept;
  logic [31:0] aMag, bMag;
  logic [32:0] remShift, trialDiff;
  logic        takeBit;
  logic [31:0] remStep, quoStep;
  logic [31:0] quoFinal, remFinal;

  // A new operation is taken only from IDLE, and only when it is not being flushed.
  assign accept = (stateReg == IDLE) && start && !annul;

  // Each operand is converted to its magnitude when it is latched. -0x80000000
  // wraps back to 0x80000000, which is the correct unsigned magnitude 2^31.
  assign aMag = (signed_div && a[31]) ? (32'd0 - a) : a;
  assign bMag = (signed_div && b[31]) ? (32'd0 - b) : b;

  // One restoring step: shift in the next dividend bit, then try to subtract.
  // The borrow bit decides whether the trial result is kept.
  assign remShift  = {remReg, quoReg[31]};
  assign trialDiff = remShift - {1'b0, divMagReg};
  assign takeBit   = !trialDiff[32];
  assign remStep   = takeBit ? trialDiff[31:0] : remShift[31:0];
  assign quoStep   = {quoReg[30:0], takeBit};

  // Apply the signs after the last step: the quotient sign is the XOR of the
  // operand signs, and the remainder sign follows the dividend.
  assign quoFinal = negQuoReg ? (32'd0 - quoStep) : quoStep;
  assign remFinal = negRemReg ? (32'd0 - remStep) : remStep;

  // State register
  always_ff @(posedge clk) begin
    if (rst) stateReg <= IDLE;
    else     stateReg <= stateNext;
  end

  // Next-state logic and handshake outputs. A flush takes priority in every state.
  always_comb begin
    stateNext = stateReg;
    ready     = 1'b0;
    stall     = 1'b0;
    case (stateReg)
      IDLE: begin
        if (accept) begin
          stateNext = (b == 32'd0) ? ZERO : BUSY;
          stall     = 1'b1;
        end
      end
      ZERO: begin
        stateNext = DONE;
        stall     = 1'b1;
      end
      BUSY: begin
        if (countReg == 6'd31) stateNext = DONE;
        stall = 1'b1;
      end
      DONE: begin
        stateNext = IDLE;
        ready     = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
    if (annul) begin
      stateNext = IDLE;
      ready     = 1'b0;
    end
    if (rst) begin
      ready = 1'b0;
      stall = 1'b0;
    end
  end

  // Operand latch, iteration datapath and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      countReg  <= 6'd0;
      remReg    <= 32'd0;
      quoReg    <= 32'd0;
      divMagReg <= 32'd0;
      negQuoReg <= 1'b0;
      negRemReg <= 1'b0;
      resultReg <= 64'd0;
    end else if (accept) begin
      countReg  <= 6'd0;
      remReg    <= 32'd0;
      quoReg    <= aMag;
      divMagReg <= bMag;
      negQuoReg <= signed_div && (a[31] ^ b[31]);
      negRemReg <= signed_div && a[31];
    end else if (stateReg == BUSY && !annul) begin
      remReg   <= remStep;
      quoReg   <= quoStep;
      countReg <= countReg + 6'd1;
      if (countReg == 6'd31) resultReg <= {remFinal, quoFinal};
    end else if (stateReg == ZERO && !annul) begin
      resultReg <= 64'd0;
    end
  end

  assign result = resultReg;

endmodule

// File: tb/tb_div_unit.sv
// Testbench for div_unit. It checks the results of randomized and directed
// operations against an arithmetic reference model. It also checks latency,
// stall coverage, flush and reset behaviour.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stall;

  int checks = 0;
  int errors = 0;

  div_unit dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .a(a), .b(b), .annul(annul),
    .result(result), .ready(ready), .stall(stall)
  );

  always #5 clk = ~clk;

  // Reference model built from plain integer arithmetic.
  function automatic logic [63:0] model(input bit sd, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    if (y == 32'd0) return 64'd0;
    if (!sd) return {x % y, x / y};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sx = x;
    sy = y;
    return {32'(sx % sy), 32'(sx / sy)};
  endfunction

  // Runs one operation with start held until ready is seen.
  // Cycle 0 is the cycle in which start is first presented.
  // The operand inputs are scrambled after the start sample.
  task automatic run_op(input bit sd, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [63:0] res,
                        output int stallOnes, output logic stallAtReady);
    lat = -1;
    res = 64'd0;
    stallAtReady = 1'bx;
    @(posedge clk); #1;
    signed_div = sd; a = x; b = y; start = 1'b1; annul = 1'b0;
    #1;
    stallOnes = (stall === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) begin
        lat = k;
        res = result;
        stallAtReady = stall;
        start = 1'b0;
        break;
      end
      if (stall === 1'b1) stallOnes++;
      a = $urandom;
      b = $urandom;
      signed_div = 1'($urandom & 1);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; annul = 1'b0; signed_div = 1'b0; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++;
    if (result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    rst = 1'b0; start = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL idle_stall: got %b expected 0", stall); end
    start = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL idle_start_stall: got %b expected 1", stall); end
    start = 1'b0;
    $display("test_reset: stall=%b ready=%b result=%h", stall, ready, result);
  endtask

  task automatic test_op(input string name, input bit sd, input logic [31:0] x, input logic [31:0] y);
    int lat, sOnes, expLat;
    logic [63:0] res, exp;
    logic sReady;
    exp = model(sd, x, y);
    expLat = (y == 32'd0) ? 2 : 33;
    run_op(sd, x, y, lat, res, sOnes, sReady);
    $display("%s: sd=%0d a=%h b=%h lat=%0d result=%h expected=%h", name, sd, x, y, lat, res, exp);
    checks++;
    if (lat != expLat) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, expLat); end
    checks++;
    if (res !== exp) begin errors++; $display("FAIL %s_result: got %h expected %h", name, res, exp); end
    checks++;
    if (sOnes != expLat) begin errors++; $display("FAIL %s_stall_cycles: got %0d expected %0d", name, sOnes, expLat); end
    checks++;
    if (sReady !== 1'b0) begin errors++; $display("FAIL %s_stall_at_ready: got %b expected 0", name, sReady); end
  endtask

  task automatic test_directed();
    test_op("divu_100_7", 1'b0, 32'd100, 32'd7);
    test_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    test_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    test_op("divu_ovf_ops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    test_op("div_by_zero", 1'b0, 32'd5, 32'd0);
    test_op("div_by_zero_s", 1'b1, 32'hFFFF_FFFF, 32'd0);
  endtask

  task automatic test_annul();
    logic [63:0] held;
    int bad = 0;
    int lat, sOnes;
    logic [63:0] res;
    logic sReady;
    held = result;
    @(posedge clk); #1;
    signed_div = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1; annul = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (stall !== 1'b1 || ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL annul_busy_window: got %0d bad cycles expected 0", bad); end
    @(posedge clk); #1;
    annul = 1'b1; start = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL annul_ready_c10: got %b expected 0", ready); end
    @(posedge clk); #1;
    annul = 1'b0;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL annul_stall_c11: got %b expected 0", stall); end
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL annul_ready_c11: got %b expected 0", ready); end
    checks++;
    if (result !== held) begin errors++; $display("FAIL annul_result_held: got %h expected %h", result, held); end
    run_op(1'b0, 32'd100, 32'd7, lat, res, sOnes, sReady);
    $display("test_annul: restart lat=%0d result=%h", lat, res);
    checks++;
    if (lat != 33) begin errors++; $display("FAIL annul_restart_latency: got %0d expected 33", lat); end
    checks++;
    if (res !== {32'd2, 32'd14}) begin errors++; $display("FAIL annul_restart_result: got %h expected %h", res, {32'd2, 32'd14}); end
  endtask

  task automatic test_annul_done();
    int bad = 0;
    @(posedge clk); #1;
    signed_div = 1'b0; a = 32'd77; b = 32'd5; start = 1'b1; annul = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      if (ready !== 1'b0) bad++;
    end
    @(posedge clk); #1;
    annul = 1'b1; start = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL annul_done_ready: got %b expected 0", ready); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL annul_done_early_ready: got %0d pulses expected 0", bad); end
    @(posedge clk); #1;
    annul = 1'b0;
    checks++;
    if (ready !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL annul_done_after: got ready=%b stall=%b expected 0/0", ready, stall);
    end
    $display("test_annul_done: ready=%b stall=%b", ready, stall);
  endtask

  task automatic test_rst_busy();
    int lat, sOnes;
    logic [63:0] res;
    logic sReady;
    @(posedge clk); #1;
    signed_div = 1'b1; a = 32'hFFFF_0000; b = 32'd9; start = 1'b1; annul = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL rst_busy_stall: got %b expected 0", stall); end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL rst_busy_ready: got %b expected 0", ready); end
    checks++;
    if (result !== 64'd0) begin errors++; $display("FAIL rst_busy_result: got %h expected 0", result); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL rst_busy_idle: got %b expected 0", stall); end
    run_op(1'b0, 32'd100, 32'd7, lat, res, sOnes, sReady);
    $display("test_rst_busy: restart lat=%0d result=%h", lat, res);
    checks++;
    if (lat != 33 || res !== {32'd2, 32'd14}) begin
      errors++; $display("FAIL rst_restart: got lat=%0d res=%h expected lat=33 res=%h", lat, res, {32'd2, 32'd14});
    end
  endtask

  task automatic test_random();
    bit sd;
    logic [31:0] x, y;
    for (int i = 0; i < 30; i++) begin
      sd = 1'($urandom & 1);
      x = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 15));
        2: y = 32'd0 - 32'($urandom_range(1, 15));
        3: begin x = 32'h8000_0000; y = ($urandom & 1) ? 32'hFFFF_FFFF : 32'h8000_0000; end
        default: y = $urandom >> $urandom_range(0, 28);
      endcase
      test_op($sformatf("rand%0d", i), sd, x, y);
    end
  endtask

  // The back-to-back case issues each start as soon as the previous DONE has passed.
  task automatic test_back_to_back();
    test_op("b2b_0", 1'b1, 32'hFFFF_FF9C, 32'd7);
    test_op("b2b_1", 1'b0, 32'hFFFF_FF9C, 32'd7);
    test_op("b2b_2", 1'b1, 32'd100, 32'hFFFF_FFF9);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; a = 32'd0; b = 32'd0;
    test_reset();
    test_directed();
    test_annul();
    test_annul_done();
    test_rst_busy();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
